// File: rtl/mmm_pkg.sv
// Shared types for the branch checker: datapath widths, the in-flight
// prediction entry, and the sequential next-PC helper.
package mmm_pkg;

  localparam int XLEN = 32;
  localparam int HLEN = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [HLEN-1:0] index;
    logic [XLEN-1:0] target;
    logic            taken;
  } bpred_entry_t;

  // Fall-through PC of a branch; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] seq_next_pc(input logic [XLEN-1:0] pc);
    return pc + {{(XLEN-3){1'b0}}, 3'b100};
  endfunction

endpackage

// File: rtl/bpred_fifo.sv
// In-flight prediction queue: oldest entry is presented on head_o.
// clear_i has priority over push and pop in the same cycle.
module bpred_fifo
  import mmm_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = bpred_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  input  logic   clear_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  entry_t        mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o    = (count_r == CNT_FULL);
  assign empty_o   = (count_r == '0);
  assign push_ok_s = push_i & ~full_o & ~clear_i;
  assign pop_ok_s  = pop_i & ~empty_o & ~clear_i;
  assign head_o    = mem_r[rd_ptr_r];

  // Entry storage: write the pushed entry at the tail slot.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/branch_checker.sv
// Branch checker: queues fetch-time predictions, compares each against the
// execute-stage outcome and emits a registered resolution plus redirect.
// Optional macro BRANCH_CHECKER_PERF_EN adds saturating perf counters.
module branch_checker
  import mmm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            pred_valid_i,
  output logic            pred_ready_o,
  input  logic [XLEN-1:0] pred_pc_i,
  input  logic [XLEN-1:0] pred_target_i,
  input  logic [HLEN-1:0] pred_index_i,
  input  logic            pred_taken_i,
  input  logic            exe_valid_i,
  input  logic            exe_taken_i,
  input  logic [XLEN-1:0] exe_target_i,
  output logic            res_valid_o,
  output logic            res_taken_o,
  output logic            res_mispredict_o,
  output logic [XLEN-1:0] res_pc_o,
  output logic [XLEN-1:0] res_target_o,
  output logic [HLEN-1:0] res_index_o,
  output logic            flush_o,
  output logic [XLEN-1:0] redirect_pc_o
`ifdef BRANCH_CHECKER_PERF_EN
  ,
  output logic [31:0]     perf_branches_o,
  output logic [31:0]     perf_mispredicts_o
`endif
);

  bpred_entry_t push_data_s;
  bpred_entry_t head_s;
  logic         full_s;
  logic         empty_s;
  logic         pop_s;
  logic         emit_s;
  logic         mispredict_s;
  logic         clear_s;
  logic [XLEN-1:0] redirect_s;

  logic            res_valid_r;
  logic            res_taken_r;
  logic            res_mispredict_r;
  logic [XLEN-1:0] res_pc_r;
  logic [XLEN-1:0] res_target_r;
  logic [HLEN-1:0] res_index_r;
  logic            flush_r;
  logic [XLEN-1:0] redirect_pc_r;

  assign push_data_s = '{pc: pred_pc_i, index: pred_index_i,
                         target: pred_target_i, taken: pred_taken_i};
  assign pred_ready_o = ~full_s;
  assign pop_s        = exe_valid_i & ~empty_s;
  assign emit_s       = pop_s & ~flush_i;

  // Compare the oldest prediction with the resolved outcome.
  always_comb begin
    mispredict_s = 1'b0;
    redirect_s   = '0;
    clear_s      = flush_i;
    mispredict_s = (head_s.taken != exe_taken_i) |
                   (exe_taken_i & (head_s.target != exe_target_i));
    if (exe_taken_i) begin
      redirect_s = exe_target_i;
    end else begin
      redirect_s = seq_next_pc(head_s.pc);
    end
    if (pop_s & mispredict_s) begin
      clear_s = 1'b1;
    end else begin
      clear_s = flush_i;
    end
  end

  bpred_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (bpred_entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (pred_valid_i),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .clear_i     (clear_s),
    .head_o      (head_s),
    .full_o      (full_s),
    .empty_o     (empty_s)
  );

  // Resolution registers: strobes pulse for one cycle, payload holds.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_valid_r      <= 1'b0;
      res_taken_r      <= 1'b0;
      res_mispredict_r <= 1'b0;
      res_pc_r         <= '0;
      res_target_r     <= '0;
      res_index_r      <= '0;
      flush_r          <= 1'b0;
      redirect_pc_r    <= '0;
    end else begin
      res_valid_r <= emit_s;
      flush_r     <= emit_s & mispredict_s;
      if (emit_s) begin
        res_taken_r      <= exe_taken_i;
        res_mispredict_r <= mispredict_s;
        res_pc_r         <= head_s.pc;
        res_target_r     <= exe_target_i;
        res_index_r      <= head_s.index;
        redirect_pc_r    <= redirect_s;
      end
    end
  end

  assign res_valid_o      = res_valid_r;
  assign res_taken_o      = res_taken_r;
  assign res_mispredict_o = res_mispredict_r;
  assign res_pc_o         = res_pc_r;
  assign res_target_o     = res_target_r;
  assign res_index_o      = res_index_r;
  assign flush_o          = flush_r;
  assign redirect_pc_o    = redirect_pc_r;

`ifdef BRANCH_CHECKER_PERF_EN
  logic [31:0] perf_branches_r;
  logic [31:0] perf_mispredicts_r;

  // Saturating counts of emitted resolutions and mispredicts.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_branches_r    <= 32'd0;
      perf_mispredicts_r <= 32'd0;
    end else begin
      if (emit_s && (perf_branches_r != 32'hFFFF_FFFF)) begin
        perf_branches_r <= perf_branches_r + 32'd1;
      end
      if (emit_s && mispredict_s && (perf_mispredicts_r != 32'hFFFF_FFFF)) begin
        perf_mispredicts_r <= perf_mispredicts_r + 32'd1;
      end
    end
  end

  assign perf_branches_o    = perf_branches_r;
  assign perf_mispredicts_o = perf_mispredicts_r;
`endif

endmodule
